// File: rtl/spi_coord_scheduler.sv
// Coordinate scheduler: captures (x,y) from N_SRC trackers and round-robins fresh data into a
// stable snapshot for spi_packer, re-staged after every spi_slave req pulse.
module spi_coord_scheduler #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9,
    parameter int unsigned IDW   = ($clog2(N_SRC) > 0) ? $clog2(N_SRC) : 1,
    parameter int unsigned OVW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    src_valid,
    input  logic [N_SRC*XW-1:0] src_xdata,
    input  logic [N_SRC*YW-1:0] src_ydata,
    input  logic                req,
    output logic [XW-1:0]       xdata,
    output logic [YW-1:0]       ydata,
    output logic [IDW-1:0]      tx_id,
    output logic                tx_stale,
    output logic [N_SRC-1:0]    fresh,
    output logic [OVW-1:0]      overrun_cnt
);

    typedef enum logic [1:0] {StWait, StSelect, StStage} state_e;

    state_e             state_q, state_d;
    logic [XW-1:0]      hold_x_q [N_SRC];
    logic [YW-1:0]      hold_y_q [N_SRC];
    logic [N_SRC-1:0]   fresh_q, fresh_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     sel_q;
    logic               no_win_q;
    logic [XW-1:0]      xdata_q;
    logic [YW-1:0]      ydata_q;
    logic [IDW-1:0]     tx_id_q;
    logic               tx_stale_q;
    logic [OVW-1:0]     overrun_q;

    logic               search_hit;
    logic [IDW-1:0]     search_idx;
    logic [IDW-1:0]     cand;

    // Round-robin search starting one past the last winner.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = IDW'((32'(ptr_q) + k) % N_SRC);
            if (!search_hit && fresh_q[cand]) begin
                search_hit = 1'b1;
                search_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:   if (req || (tx_stale_q && |fresh_q)) state_d = StSelect;
            StSelect: state_d = StStage;
            StStage:  state_d = StWait;
            default:  state_d = StWait;
        endcase
    end

    // Capture is applied after the STAGE clear so a same-cycle strobe keeps the source fresh.
    always_comb begin
        fresh_d = fresh_q;
        if (state_q == StStage && !no_win_q) fresh_d[sel_q] = 1'b0;
        fresh_d = fresh_d | src_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StWait;
            fresh_q    <= '0;
            ptr_q      <= IDW'(N_SRC - 1);
            sel_q      <= '0;
            no_win_q   <= 1'b1;
            xdata_q    <= '0;
            ydata_q    <= '0;
            tx_id_q    <= '0;
            tx_stale_q <= 1'b1;
            overrun_q  <= '0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                hold_x_q[i] <= '0;
                hold_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fresh_q <= fresh_d;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (src_valid[i]) begin
                    hold_x_q[i] <= src_xdata[i*XW +: XW];
                    hold_y_q[i] <= src_ydata[i*YW +: YW];
                end
            end
            if (state_q == StWait && req) tx_stale_q <= 1'b1;
            if (state_q == StSelect) begin
                sel_q    <= search_idx;
                no_win_q <= !search_hit;
            end
            if (state_q == StStage && !no_win_q) begin
                xdata_q    <= hold_x_q[sel_q];
                ydata_q    <= hold_y_q[sel_q];
                tx_id_q    <= sel_q;
                tx_stale_q <= 1'b0;
                ptr_q      <= sel_q;
            end
            if (req && state_q != StWait && overrun_q != {OVW{1'b1}}) begin
                overrun_q <= overrun_q + 1'b1;
            end
        end
    end

    assign xdata       = xdata_q;
    assign ydata       = ydata_q;
    assign tx_id       = tx_id_q;
    assign tx_stale    = tx_stale_q;
    assign fresh       = fresh_q;
    assign overrun_cnt = overrun_q;

endmodule
